// File: rtl/tt_um_counter_sched.sv
// rtl/tt_um_counter_sched.sv - command-driven sequencer for the 8-bit event counter tile
module tt_um_counter_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP            = 3'd0;
    localparam logic [2:0] OP_LOAD_LIMIT     = 3'd1;
    localparam logic [2:0] OP_START_ONESHOT  = 3'd2;
    localparam logic [2:0] OP_START_PERIODIC = 3'd3;
    localparam logic [2:0] OP_PAUSE          = 3'd4;
    localparam logic [2:0] OP_RESUME         = 3'd5;
    localparam logic [2:0] OP_STOP           = 3'd6;
    localparam logic [2:0] OP_SET_PRESCALE   = 3'd7;

    state_t     state;
    logic       mode;
    logic       done;
    logic [3:0] wrap_cnt;
    logic [7:0] count;
    logic [7:0] limit;
    logic [3:0] prescale;
    logic [3:0] pre_cnt;

    logic       stb_s1;
    logic       stb_s2;
    logic       stb_d;

    logic [2:0] opcode;
    logic       cmd_fire;
    logic       cmd_start;
    logic       cmd_stop;
    logic       cmd_pause;
    logic       run_step;
    logic       tick;

    // ena and the spare input bits carry no function in this tile
    logic       unused_inputs;
    assign unused_inputs = &{1'b0, ena, ui_in[6:4]};

    assign opcode    = ui_in[3:1];
    assign cmd_fire  = stb_s2 & ~stb_d;
    assign cmd_start = cmd_fire && ((opcode == OP_START_ONESHOT) || (opcode == OP_START_PERIODIC));
    assign cmd_stop  = cmd_fire && (opcode == OP_STOP);
    assign cmd_pause = cmd_fire && (opcode == OP_PAUSE);

    // START/STOP/PAUSE own the cycle they execute in, so the prescaler step is skipped then
    assign run_step  = (state == RUN) && !(cmd_start || cmd_stop || cmd_pause);
    assign tick      = (pre_cnt == prescale);

    // Strobe synchronizer plus delay flop; one command per rising edge of cmd_stb
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_s1 <= 1'b0;
            stb_s2 <= 1'b0;
            stb_d  <= 1'b0;
        end else begin
            stb_s1 <= ui_in[0];
            stb_s2 <= stb_s1;
            stb_d  <= stb_s2;
        end
    end

    // Sequencer FSM and counter datapath; command updates land after the tick so they win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode     <= 1'b0;
            done     <= 1'b0;
            wrap_cnt <= 4'd0;
            count    <= 8'd0;
            limit    <= 8'hFF;
            prescale <= 4'd0;
            pre_cnt  <= 4'd0;
        end else begin
            if (run_step) begin
                if (tick) begin
                    pre_cnt <= 4'd0;
                    if (count != limit) begin
                        count <= count + 8'd1;
                    end else if (!mode) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count    <= 8'd0;
                        done     <= 1'b1;
                        wrap_cnt <= wrap_cnt + 4'd1;
                    end
                end else begin
                    pre_cnt <= pre_cnt + 4'd1;
                end
            end

            if (cmd_fire) begin
                case (opcode)
                    OP_LOAD_LIMIT: begin
                        limit <= uio_in;
                    end
                    OP_START_ONESHOT, OP_START_PERIODIC: begin
                        count    <= 8'd0;
                        pre_cnt  <= 4'd0;
                        mode     <= (opcode == OP_START_PERIODIC);
                        done     <= 1'b0;
                        wrap_cnt <= 4'd0;
                        state    <= RUN;
                    end
                    OP_PAUSE: begin
                        if (state == RUN) state <= HOLD;
                    end
                    OP_RESUME: begin
                        if (state == HOLD) state <= RUN;
                    end
                    OP_STOP: begin
                        count    <= 8'd0;
                        pre_cnt  <= 4'd0;
                        done     <= 1'b0;
                        wrap_cnt <= 4'd0;
                        state    <= IDLE;
                    end
                    OP_SET_PRESCALE: begin
                        prescale <= uio_in[3:0];
                    end
                    OP_NOP: begin
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output view mux: count or status byte, selected live by ui_in[7]
    always_comb begin
        uo_out = count;
        if (ui_in[7]) uo_out = {state, mode, done, wrap_cnt};
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: doc/tt_um_counter_sched.md
# tt_um_counter_sched

Command-driven controller that sequences the 8-bit event counter datapath in the TinyTapeout tile. Commands arrive as an opcode on `ui_in` and an operand on `uio_in`, qualified by a strobe pin. The block starts, pauses, resumes and stops the counter, and loads its terminal limit and tick prescaler. It runs the counter in one-shot or periodic (auto-reload) mode and shows either the count or a status byte on `uo_out`.

## Interface
No parameters; all widths fixed.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `ena` input 1: always 1 when powered; unused.
- `ui_in` input 8:
  - [0] `cmd_stb`, asynchronous command strobe.
  - [3:1] opcode.
  - [6:4] unused.
  - [7] `view` (0 = count, 1 = status).
- `uio_in` input 8: command operand.
- `uo_out` output 8: `count` when `view`=0, status byte when `view`=1. Combinational mux of registered values.
- `uio_out` output 8: constant 0.
- `uio_oe` output 8: constant 0; all bidirectional pins are inputs.

## Operation
- **Registers and reset values:**
  - `count` = 0, `limit` = 8'hFF, `prescale` (4b) = 0, `pre_cnt` (4b) = 0.
  - `state` = IDLE, `mode` = 0 (one-shot), `done` = 0, `wrap_cnt` (4b) = 0.
  - Synchronizer flops = 0.
  - `uo_out` = 0 in reset for either `view`.
- **Status byte:** {`state`[1:0], `mode`, `done`, `wrap_cnt`[3:0]}.
- **State encoding:** IDLE=0, RUN=1, HOLD=2, DONE=3.
- **Strobe handling:**
  - `cmd_stb` passes through a 2-flop synchronizer plus a delay flop for edge detection.
  - One command executes per rising edge of `cmd_stb`. Holding it high does not repeat the command.
- **Opcodes:**
  - 0 NOP.
  - 1 LOAD_LIMIT: `limit` <= `uio_in`. Allowed in any state.
  - 2 START_ONESHOT: `count`, `pre_cnt` <= 0; `mode` <= 0; `done` <= 0; `wrap_cnt` <= 0; state -> RUN. Allowed from any state.
  - 3 START_PERIODIC: same as START_ONESHOT, but `mode` <= 1.
  - 4 PAUSE: RUN -> HOLD. Ignored in other states.
  - 5 RESUME: HOLD -> RUN. Ignored in other states.
  - 6 STOP: any state -> IDLE; `count`, `pre_cnt`, `done`, `wrap_cnt` <= 0. `limit` and `prescale` are kept.
  - 7 SET_PRESCALE: `prescale` <= `uio_in`[3:0]. Allowed in any state.
- **Tick generation (RUN only):**
  - Each cycle: if `pre_cnt` == `prescale`, then `pre_cnt` <= 0 and a tick is asserted; otherwise `pre_cnt` <= `pre_cnt` + 1.
  - In HOLD, `pre_cnt` is frozen, so phase is preserved across PAUSE/RESUME.
  - In IDLE and DONE, `pre_cnt` holds its value and no tick is generated.
- **On tick:**
  - If `count` != `limit`: `count` <= `count` + 1, with natural 8-bit wrap 255 -> 0.
  - If `count` == `limit` and one-shot: `count` holds; `done` <= 1; state -> DONE.
  - If `count` == `limit` and periodic: `count` <= 0; `done` <= 1; `wrap_cnt` <= `wrap_cnt` + 1 (mod 16); stays in RUN.
- **Comparison rule:** equality only. If `limit` is loaded below the current `count` mid-run, counting continues through 255 -> 0 and stops at the next match.
- **`limit` = 0:** one-shot reaches DONE on the first tick; periodic wraps on every tick.
- **`done` flag:** sticky; cleared only by START or STOP.

## Timing
- **Command latency:**
  - `ui_in`[0] high at rising edge k executes the command at edge k+2.
  - Opcode and `uio_in` are sampled at edge k+2. The host holds them stable from the strobe rise through that edge (≥3 cycles).
  - Register effects are visible on `uo_out` after edge k+2.
- **Command and tick in the same cycle:**
  - START, STOP and PAUSE suppress the tick.
  - All other commands coexist with the tick. The tick uses the pre-update `limit` and `prescale`.
- **START timing:** after the START edge with prescale P, `count` becomes 1 at the (P+1)th edge, then advances every P+1 cycles.
- **Reset:** asserting `rst_n` low mid-operation clears all state immediately (asynchronous). Release is synchronous to `clk`.
- **View select:** `view` is not synchronized; `uo_out` follows it combinationally.

## Test plan
- **Reset:** reset, `view`=0/1 -> `uo_out` = 0x00 both. `rst_n` low mid-RUN -> `uo_out` = 0x00 in the same cycle.
- **One-shot:** LOAD_LIMIT 5, then START_ONESHOT, prescale 0 -> `count` 1..5 on consecutive cycles, then holds 5. Status = 0xD0.
- **Periodic:** SET_PRESCALE 1, LOAD_LIMIT 3, START_PERIODIC:
  - `count` sequence is 0,0,1,1,2,2,3,3,0…
  - Status = 0x71 after the first wrap.
  - `wrap_cnt` returns to 0 after 16 wraps.
- **Pause/resume:** PAUSE at `count`=7 -> `count` frozen 20 cycles, status [7:6]=2. RESUME -> `count` 8 after the remaining prescale phase. PAUSE in IDLE is ignored.
- **Strobe:** `cmd_stb` held high 50 cycles with START -> one execution only. LOAD_LIMIT 2 while running at `count`=10 -> counts through 255 -> 0, then DONE at 2.
- **STOP from DONE:** -> status 0x00 and `count` 0; `limit` is retained (next START_ONESHOT stops at the old `limit`).
